// File: rtl/ifft_4p_serial_if.sv
// Stream bundle for the 4-point inverse FFT: input sample stream (s_*) and
// output sample stream (m_*), complex words packed as {imag, real}.
interface ifft_4p_serial_if #(
  parameter int DATAWIDTH = 32
);
  logic [DATAWIDTH-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [DATAWIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic                 m_last;

  // slave: the transform block itself; master: the environment around it
  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );
endinterface

// File: rtl/ifft_4p_serial.sv
// Streaming 4-point radix-2 inverse FFT: collect X[0..3], two halving
// butterfly stages (total 1/N), then emit x[0..3] in natural order.
module ifft_4p_serial #(
  parameter int DATAWIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  ifft_4p_serial_if.slave bus
);

  localparam int W = DATAWIDTH / 2;

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_STAGE1  = 2'd1;
  localparam logic [1:0] S_STAGE2  = 2'd2;
  localparam logic [1:0] S_EMIT    = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           r_in_cnt;
  logic [1:0]           r_out_cnt;
  logic [DATAWIDTH-1:0] r_x_p0 [4];
  logic [DATAWIDTH-1:0] r_a_p1;
  logic [DATAWIDTH-1:0] r_b_p1;
  logic [DATAWIDTH-1:0] r_c_p1;
  logic [DATAWIDTH-1:0] r_d_p1;
  logic [DATAWIDTH-1:0] r_y_p2 [4];

  logic w_s_ready;
  logic w_m_valid;
  logic w_in_xfer;
  logic w_out_xfer;

  function automatic logic signed [W-1:0] re_of(input logic [DATAWIDTH-1:0] z);
    return $signed(z[W-1:0]);
  endfunction

  function automatic logic signed [W-1:0] im_of(input logic [DATAWIDTH-1:0] z);
    return $signed(z[DATAWIDTH-1:W]);
  endfunction

  // (a +/- b) / 2 with one guard bit; arithmetic shift floors, and the
  // halved result always fits back into W bits, so no saturation is needed.
  function automatic logic signed [W-1:0] half_sum(
    input logic signed [W-1:0] a,
    input logic signed [W-1:0] b,
    input logic                sub
  );
    logic signed [W:0] ae;
    logic signed [W:0] be;
    logic signed [W:0] s;
    logic signed [W:0] h;
    ae = {a[W-1], a};
    be = {b[W-1], b};
    s  = sub ? (ae - be) : (ae + be);
    h  = s >>> 1;
    return h[W-1:0];
  endfunction

  function automatic logic [DATAWIDTH-1:0] cbutterfly(
    input logic [DATAWIDTH-1:0] p,
    input logic [DATAWIDTH-1:0] q,
    input logic                 sub
  );
    return {half_sum(im_of(p), im_of(q), sub), half_sum(re_of(p), re_of(q), sub)};
  endfunction

  assign w_s_ready  = (r_state == S_COLLECT) && !rst;
  assign w_m_valid  = (r_state == S_EMIT) && !rst;
  assign w_in_xfer  = bus.s_valid && w_s_ready;
  assign w_out_xfer = w_m_valid && bus.m_ready;

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = w_m_valid;
  assign bus.m_last  = w_m_valid && (r_out_cnt == 2'd3);
  assign bus.m_data  = w_m_valid ? r_y_p2[r_out_cnt] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_COLLECT;
      r_in_cnt  <= 2'd0;
      r_out_cnt <= 2'd0;
      r_a_p1    <= '0;
      r_b_p1    <= '0;
      r_c_p1    <= '0;
      r_d_p1    <= '0;
      for (int i = 0; i < 4; i++) begin
        r_x_p0[i] <= '0;
        r_y_p2[i] <= '0;
      end
    end else begin
      case (r_state)
        // p0: frame buffer fill
        S_COLLECT: begin
          if (w_in_xfer) begin
            r_x_p0[r_in_cnt] <= bus.s_data;
            r_in_cnt         <= r_in_cnt + 2'd1;
            if (r_in_cnt == 2'd3) r_state <= S_STAGE1;
          end
        end
        // p1: first butterfly stage, pairs (X0,X2) and (X1,X3)
        S_STAGE1: begin
          r_a_p1  <= cbutterfly(r_x_p0[0], r_x_p0[2], 1'b0);
          r_b_p1  <= cbutterfly(r_x_p0[0], r_x_p0[2], 1'b1);
          r_c_p1  <= cbutterfly(r_x_p0[1], r_x_p0[3], 1'b0);
          r_d_p1  <= cbutterfly(r_x_p0[1], r_x_p0[3], 1'b1);
          r_state <= S_STAGE2;
        end
        // p2: second stage; the inverse twiddle is +j, so D is rotated by +j for x1
        S_STAGE2: begin
          r_y_p2[0] <= cbutterfly(r_a_p1, r_c_p1, 1'b0);
          r_y_p2[2] <= cbutterfly(r_a_p1, r_c_p1, 1'b1);
          r_y_p2[1] <= {half_sum(im_of(r_b_p1), re_of(r_d_p1), 1'b0),
                        half_sum(re_of(r_b_p1), im_of(r_d_p1), 1'b1)};
          r_y_p2[3] <= {half_sum(im_of(r_b_p1), re_of(r_d_p1), 1'b1),
                        half_sum(re_of(r_b_p1), im_of(r_d_p1), 1'b0)};
          r_state   <= S_EMIT;
        end
        S_EMIT: begin
          if (w_out_xfer) begin
            r_out_cnt <= r_out_cnt + 2'd1;
            if (r_out_cnt == 2'd3) r_state <= S_COLLECT;
          end
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule
